uart_rx_fifo: RTL and testbench

//  Receive-side buffer downstream of the UART receiver: detects each completed

---
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive-side byte FIFO behind the UART receiver. It detects the
//            end of each frame on rx_busy, queues the received byte, and gives
//            the CPU first-word-fall-through reads. It also keeps a sticky
//            overflow flag and a level interrupt.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          rx_busy,
  input  logic [7:0]    rx_data,
  input  logic          rx_enable,
  input  logic          rd_en,
  input  logic          irq_en,
  input  logic          ovf_clr,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          irq
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  // rx_busy synchroniser (s1, s2) plus one history flop (s3)
  logic          s1_q, s2_q, s3_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem [DEPTH];

  logic          done_w;
  logic          push_req_w;
  logic          do_pop_w;
  logic          do_push_w;
  logic          ovf_set_w;

  // Synchronise rx_busy; the flops reset to 0 so a release never fakes a falling edge
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= rx_busy;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign done_w     = s3_q & ~s2_q;
  assign push_req_w = done_w & rx_enable;
  assign empty      = (count_q == '0);
  assign full       = (count_q == C_DEPTH);
  assign do_pop_w   = rd_en & ~empty;
  // A full FIFO still accepts a byte if the head leaves in the same cycle
  assign do_push_w  = push_req_w & (~full | do_pop_w);
  assign ovf_set_w  = push_req_w & full & ~do_pop_w;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push_w) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push_w && !do_pop_w)      count_d = count_q + C_ONE;
    else if (do_pop_w && !do_push_w) count_d = count_q - C_ONE;
    // A new overflow takes priority over a clear in the same cycle
    if (ovf_set_w)    ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Control state register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage; contents are not cleared by reset
  always_ff @(posedge sysclk) begin
    if (do_push_w) mem[wr_ptr_q] <= rx_data;
  end

  assign rd_data  = empty ? 8'h00 : mem[rd_ptr_q];
  assign count    = count_q;
  assign overflow = ovf_q;
  assign irq      = irq_en & ~empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo with a byte
//            scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       rx_busy, rx_enable, rd_en, irq_en, ovf_clr;
  logic [7:0] rx_data;
  logic [7:0] rd_data;
  logic       empty, full, overflow, irq;
  logic [4:0] count;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] sb[$];

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .sysclk(sysclk), .reset(reset), .rx_busy(rx_busy), .rx_data(rx_data),
    .rx_enable(rx_enable), .rd_en(rd_en), .irq_en(irq_en), .ovf_clr(ovf_clr),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .irq(irq)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One frame: busy high 10 cycles then low; optional pop / ovf_clr in the done cycle
  task automatic send_frame(input logic [7:0] d, input bit exp_push,
                            input bit pop_at_done, input bit clr_at_done);
    logic [4:0] pre;
    logic [7:0] head;
    rx_data = d;
    rx_busy = 1'b1;
    repeat (10) tick();
    rx_busy = 1'b0;
    pre = count;
    tick();
    tick();
    chk("latency_hold", {27'd0, count}, {27'd0, pre});
    if (pop_at_done) begin
      if (sb.size() == 0) head = 8'h00;
      else head = sb.pop_front();
      chk("pop_at_done_data", {24'd0, rd_data}, {24'd0, head});
      rd_en = 1'b1;
    end
    if (clr_at_done) ovf_clr = 1'b1;
    tick();
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    if (exp_push) sb.push_back(d);
  endtask

  task automatic pop_one();
    logic [7:0] head;
    head = sb.pop_front();
    chk("pop_data", {24'd0, rd_data}, {24'd0, head});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rx_busy = 1'b0; rx_enable = 1'b1; rd_en = 1'b0;
    irq_en = 1'b0; ovf_clr = 1'b0; rx_data = 8'h00;

    // 1: reset held while inputs toggle
    for (int i = 0; i < 8; i++) begin
      rx_busy = i[0]; rd_en = i[1]; irq_en = 1'b1; ovf_clr = i[2];
      rx_data = 8'(i * 37);
      tick();
    end
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    rx_busy = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; irq_en = 1'b1;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("release_count", {27'd0, count}, 32'd0);

    // 2: single byte
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("single_count", {27'd0, count}, 32'd1);
    chk("single_rd_data", {24'd0, rd_data}, 32'hA5);
    chk("single_irq", {31'd0, irq}, 32'd1);
    irq_en = 1'b0;
    #1;
    chk("irq_masked", {31'd0, irq}, 32'd0);
    irq_en = 1'b1;
    pop_one();
    chk("single_empty", {31'd0, empty}, 32'd1);
    chk("single_irq_off", {31'd0, irq}, 32'd0);

    // 3: fill, wrap, drain
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {27'd0, count}, 32'd16);
    repeat (4) pop_one();
    chk("pop4_count", {27'd0, count}, 32'd12);
    for (int i = 16; i < 20; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    chk("wrap_full", {31'd0, full}, 32'd1);
    while (sb.size() > 0) pop_one();
    chk("wrap_empty", {31'd0, empty}, 32'd1);
    chk("wrap_count", {27'd0, count}, 32'd0);

    // 4: overflow set/clear, set wins over clear
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {27'd0, count}, 32'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared2", {31'd0, overflow}, 32'd0);

    // 5: simultaneous push/pop when full, then when empty
    send_frame(8'h30, 1'b1, 1'b1, 1'b0);
    chk("sim_full_count", {27'd0, count}, 32'd16);
    chk("sim_full_ovf", {31'd0, overflow}, 32'd0);
    while (sb.size() > 0) pop_one();
    chk("sim_drain_empty", {31'd0, empty}, 32'd1);
    send_frame(8'h40, 1'b1, 1'b1, 1'b0);
    chk("sim_empty_count", {27'd0, count}, 32'd1);
    pop_one();

    // 6: gating, pop on empty, reset mid-frame
    rx_enable = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    chk("gate_count", {27'd0, count}, 32'd0);
    rx_enable = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pop_empty_count", {27'd0, count}, 32'd0);
    chk("pop_empty_data", {24'd0, rd_data}, 32'd0);
    rx_data = 8'h66;
    rx_busy = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    rx_busy = 1'b0;
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("rst_midframe_count", {27'd0, count}, 32'd0);
    send_frame(8'h77, 1'b1, 1'b0, 1'b0);
    chk("after_rst_count", {27'd0, count}, 32'd1);
    pop_one();
    chk("final_empty", {31'd0, empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
